// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one ack-handshaked memory between fetch and data ports; data has priority, fetch starvation bounded.
// Optional abort on a stuck transaction is enabled with MEMARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int MAX_D_STREAK   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY_IF = 2'd1;
  localparam logic [1:0] BUSY_D  = 2'd2;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

  logic [1:0] state;
  logic [3:0] streak;
  logic       if_elig;
  logic       d_elig;
  logic       grant_d;
  logic       grant_if;
  logic       abort;

  // Streak only grows while fetch is actually being passed over.
  function automatic logic [3:0] streak_next(input logic [3:0] cur, input logic if_pending);
    if (!if_pending)
      return 4'd0;
    if (cur >= STREAK_MAX)
      return STREAK_MAX;
    return cur + 4'd1;
  endfunction

  // A requester sitting in its valid cycle is still holding req for the old transaction.
  assign if_elig  = if_req & ~if_valid;
  assign d_elig   = d_req & ~d_valid;
  assign grant_d  = d_elig & ~(if_elig & (streak == STREAK_MAX));
  assign grant_if = if_elig & ~grant_d;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

`ifdef MEMARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TO_W-1:0] to_cnt;

  // Abort fires at the end of the TIMEOUT_CYCLES-th unacked busy cycle; an ack in that cycle wins.
  assign abort = (state != IDLE) & ~mem_ack & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset)
      to_cnt <= '0;
    else if (state == IDLE)
      to_cnt <= '0;
    else if (!mem_ack)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      d_rdata   <= 32'd0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= BUSY_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            streak    <= streak_next(streak, if_elig);
          end else if (grant_if) begin
            state    <= BUSY_IF;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
            streak   <= 4'd0;
          end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        BUSY_IF: begin
          if (mem_ack || abort) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : 32'd0;
            err      <= ~mem_ack;
          end
        end
        BUSY_D: begin
          if (mem_ack || abort) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_valid <= 1'b1;
            err     <= ~mem_ack;
            if (!mem_ack)
              d_rdata <= 32'd0;
            else if (!mem_we)
              d_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-accurate vector table plus reset, starvation and timeout sequences.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        err;

  int checks;
  int failures;

  mem_port_arbiter #(
    .MAX_D_STREAK   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_valid  (if_valid),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_valid   (d_valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fi = {if_req, d_req, d_we, mem_ack}
  // fo = {mem_req, mem_we, if_valid, d_valid, stall_if, stall_mem}
  typedef struct {
    logic [3:0]  fi;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [31:0] rd;
    logic [5:0]  fo;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] ifrd;
    logic [31:0] drd;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_flags"}, 32'({mem_req, mem_we, if_valid, d_valid, err}), 32'd0);
    chk({nm, "_maddr"}, mem_addr, 32'd0);
    chk({nm, "_mwdata"}, mem_wdata, 32'd0);
    chk({nm, "_ifrdata"}, if_rdata, 32'd0);
    chk({nm, "_drdata"}, d_rdata, 32'd0);
  endtask

  logic [31:0] grants[$];
  logic [31:0] exp_grants[11];
  int          n;

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    if_req    = 1'b1;
    if_addr   = 32'h0000_0010;
    d_req     = 1'b1;
    d_we      = 1'b0;
    d_addr    = 32'h0000_0040;
    d_wdata   = 32'h1234_5678;
    mem_rdata = 32'd0;
    mem_ack   = 1'b0;

    tbl[0]  = '{4'b1000, 32'h10, 32'h0,  32'h0,        32'h0,        6'b000010, 32'h0,  32'h0,        32'h0,        32'h0};
    tbl[1]  = '{4'b1001, 32'h10, 32'h0,  32'h0,        32'h00510113, 6'b100010, 32'h10, 32'h0,        32'h0,        32'h0};
    tbl[2]  = '{4'b1000, 32'h10, 32'h0,  32'h0,        32'h0,        6'b001000, 32'h10, 32'h0,        32'h00510113, 32'h0};
    tbl[3]  = '{4'b0000, 32'h0,  32'h0,  32'h0,        32'h0,        6'b000000, 32'h10, 32'h0,        32'h00510113, 32'h0};
    tbl[4]  = '{4'b1100, 32'h20, 32'h40, 32'h0,        32'h0,        6'b000011, 32'h10, 32'h0,        32'h00510113, 32'h0};
    tbl[5]  = '{4'b1101, 32'h20, 32'h40, 32'h0,        32'h11112222, 6'b100011, 32'h40, 32'h0,        32'h00510113, 32'h0};
    tbl[6]  = '{4'b1100, 32'h20, 32'h40, 32'h0,        32'h0,        6'b000110, 32'h40, 32'h0,        32'h00510113, 32'h11112222};
    tbl[7]  = '{4'b1001, 32'h20, 32'h0,  32'h0,        32'h33334444, 6'b100010, 32'h20, 32'h0,        32'h00510113, 32'h11112222};
    tbl[8]  = '{4'b1000, 32'h20, 32'h0,  32'h0,        32'h0,        6'b001000, 32'h20, 32'h0,        32'h33334444, 32'h11112222};
    tbl[9]  = '{4'b0000, 32'h0,  32'h0,  32'h0,        32'h0,        6'b000000, 32'h20, 32'h0,        32'h33334444, 32'h11112222};
    tbl[10] = '{4'b0110, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b000001, 32'h20, 32'h0,        32'h33334444, 32'h11112222};
    tbl[11] = '{4'b0100, 32'h0,  32'h99, 32'h0,        32'h0,        6'b110001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[12] = '{4'b0100, 32'h0,  32'h99, 32'h0,        32'h0,        6'b110001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[13] = '{4'b0100, 32'h0,  32'h99, 32'h0,        32'h0,        6'b110001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[14] = '{4'b0101, 32'h0,  32'h99, 32'h0,        32'hBAD0BAD0, 6'b110001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[15] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b000100, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[16] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b000001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[17] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b100001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[18] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b100001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[19] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b100001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[20] = '{4'b0101, 32'h0,  32'h64, 32'hDEADBEEF, 32'hDEADBEEF, 6'b100001, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'h11112222};
    tbl[21] = '{4'b0100, 32'h0,  32'h64, 32'hDEADBEEF, 32'h0,        6'b000100, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'hDEADBEEF};
    tbl[22] = '{4'b0000, 32'h0,  32'h0,  32'h0,        32'h0,        6'b000000, 32'h64, 32'hDEADBEEF, 32'h33334444, 32'hDEADBEEF};

    // Reset held with both requests pending: nothing may start.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk_all_zero($sformatf("reset_hold%0d", i));
    end
    reset = 1'b1;
    #1;
    chk("release_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("first_grant_req", 32'(mem_req), 32'd1);
    chk("first_grant_addr", mem_addr, 32'h40);

    // Reset mid-transaction beats a simultaneous ack.
    reset   = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk_all_zero("mid_reset");
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    reset   = 1'b1;

    for (int i = 0; i < 23; i++) begin
      {if_req, d_req, d_we, mem_ack} = tbl[i].fi;
      if_addr   = tbl[i].ia;
      d_addr    = tbl[i].da;
      d_wdata   = tbl[i].dwd;
      mem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("row%0d_flags", i),
          32'({mem_req, mem_we, if_valid, d_valid, stall_if, stall_mem}), 32'(tbl[i].fo));
      chk($sformatf("row%0d_maddr", i), mem_addr, tbl[i].maddr);
      chk($sformatf("row%0d_mwdata", i), mem_wdata, tbl[i].mwd);
      chk($sformatf("row%0d_ifrdata", i), if_rdata, tbl[i].ifrd);
      chk($sformatf("row%0d_drdata", i), d_rdata, tbl[i].drd);
      chk($sformatf("row%0d_err", i), 32'(err), 32'd0);
      @(negedge clk);
    end

    // Starvation: fetch drops its request only while a data valid is showing, so the streak can build.
    for (int i = 0; i < 11; i++)
      exp_grants[i] = 32'h2000;
    exp_grants[4]  = 32'h1000;
    exp_grants[10] = 32'h1000;
    if_addr = 32'h1000;
    d_addr  = 32'h2000;
    d_we    = 1'b0;
    d_req   = 1'b1;
    for (int k = 0; k < 80 && grants.size() < 11; k++) begin
      if_req  = ~d_valid;
      mem_ack = mem_req;
      #1;
      if (mem_req)
        grants.push_back(mem_addr);
      if (grants.size() < 11)
        @(negedge clk);
    end
    chk("starve_grant_count", 32'(grants.size()), 32'd11);
    for (int i = 0; i < 11 && i < grants.size(); i++)
      chk($sformatf("starve_grant%0d", i), grants[i], exp_grants[i]);
    @(negedge clk);
    if_req  = 1'b0;
    d_req   = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Stuck memory: ack never arrives.
    d_addr = 32'h80;
    d_we   = 1'b0;
    d_req  = 1'b1;
    n = 0;
`ifdef MEMARB_TIMEOUT_EN
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (!mem_req)
        break;
      n++;
    end
    chk("timeout_busy_cycles", 32'(n), 32'd8);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_dvalid", 32'(d_valid), 32'd1);
    chk("timeout_drdata", d_rdata, 32'd0);
    @(negedge clk);
    d_addr = 32'h84;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 7) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
      end
    end
    @(negedge clk);
    #1;
    chk("ackwin_dvalid", 32'(d_valid), 32'd1);
    chk("ackwin_err", 32'(err), 32'd0);
    chk("ackwin_drdata", d_rdata, 32'h5A5A5A5A);
    chk("ackwin_mem_req", 32'(mem_req), 32'd0);
    d_req   = 1'b0;
    mem_ack = 1'b0;
`else
    @(negedge clk);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (mem_req && !err && !d_valid)
        n++;
    end
    chk("no_timeout_held_cycles", 32'(n), 32'd100);
    d_req = 1'b0;
`endif
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("final_reset_mem_req", 32'(mem_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
